// File: rtl/disp_arbiter.sv
// Display arbiter: rotates three sources on the 3-digit display, pre-empted by popups.
// Optional popup blink is enabled by defining DISP_ARB_POPUP_BLINK_EN.
module disp_arbiter #(
   parameter int ROT_TICKS   = 500,
   parameter int HOLD_TICKS  = 250,
   parameter int BLINK_TICKS = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [2:0] src_en,
   input  logic [9:0] src0_val,
   input  logic [9:0] src1_val,
   input  logic [9:0] src2_val,
   input  logic       pop_req,
   input  logic [9:0] pop_val,
   output logic       pop_ack,
   output logic       pop_busy,
   output logic [9:0] disp_val,
   output logic [1:0] disp_src,
   output logic       disp_blank
);

   localparam int RW = (ROT_TICKS > 1) ? $clog2(ROT_TICKS) : 1;
   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [RW-1:0] ROT_LAST  = RW'(ROT_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [RW-1:0] ROT_ONE   = RW'(1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ROTATE = 2'd1;
   localparam logic [1:0] POPUP  = 2'd2;

   logic [1:0]    state, state_n;
   logic [1:0]    cur, cur_n;
   logic [RW-1:0] rot_cnt, rot_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [9:0]    pop_lat, pop_lat_n;
   logic          accept;
   logic [9:0]    val_n;
   logic [1:0]    src_n;
   logic          blank_n;

   function automatic logic [1:0] wrap3(input logic [2:0] x);
      logic [2:0] y;
      y = (x >= 3'd3) ? x - 3'd3 : x;
      return y[1:0];
   endfunction

   // First enabled index scanning s, s+1, s+2 (mod 3).
   function automatic logic [1:0] first_from(
      input logic [2:0] en,
      input logic [1:0] s
   );
      logic [1:0] a, b, c, r;
      a = s;
      b = wrap3({1'b0, s} + 3'd1);
      c = wrap3({1'b0, s} + 3'd2);
      r = s;
      if (en[c]) r = c;
      if (en[b]) r = b;
      if (en[a]) r = a;
      return r;
   endfunction

   function automatic logic [1:0] nxt(
      input logic [2:0] en,
      input logic [1:0] s
   );
      return first_from(en, wrap3({1'b0, s} + 3'd1));
   endfunction

   function automatic logic [9:0] clamp(input logic [9:0] v);
      return (v > 10'd999) ? 10'd999 : v;
   endfunction

   assign accept = pop_req & ~pop_ack;

   always_comb begin
      state_n   = state;
      cur_n     = cur;
      rot_n     = rot_cnt;
      hold_n    = hold_cnt;
      pop_lat_n = pop_lat;
      if (accept) begin
         state_n   = POPUP;
         pop_lat_n = pop_val;
         hold_n    = '0;
      end else begin
         case (state)
            ROTATE: begin
               if (src_en == 3'b000) begin
                  state_n = IDLE;
               end else if (!src_en[cur]) begin
                  cur_n = nxt(src_en, cur);
                  rot_n = '0;
               end else if (tick) begin
                  if (rot_cnt == ROT_LAST) begin
                     cur_n = nxt(src_en, cur);
                     rot_n = '0;
                  end else begin
                     rot_n = rot_cnt + ROT_ONE;
                  end
               end
            end
            POPUP: begin
               if (tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     hold_n = '0;
                     if (src_en != 3'b000) begin
                        state_n = ROTATE;
                        cur_n   = first_from(src_en, cur);
                        rot_n   = '0;
                     end else begin
                        state_n = IDLE;
                     end
                  end else begin
                     hold_n = hold_cnt + HOLD_ONE;
                  end
               end
            end
            default: begin
               if (src_en != 3'b000) begin
                  state_n = ROTATE;
                  cur_n   = first_from(src_en, cur);
                  rot_n   = '0;
               end
            end
         endcase
      end
   end

`ifdef DISP_ARB_POPUP_BLINK_EN
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [BW-1:0] BLK_ONE  = BW'(1);

   logic [BW-1:0] blk_cnt, blk_n;
   logic          blink, blink_n;

   always_comb begin
      blk_n   = blk_cnt;
      blink_n = blink;
      if (accept) begin
         blk_n   = '0;
         blink_n = 1'b0;
      end else if (state == POPUP && tick) begin
         if (blk_cnt == BLK_LAST) begin
            blk_n   = '0;
            blink_n = ~blink;
         end else begin
            blk_n = blk_cnt + BLK_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_cnt <= '0;
         blink   <= 1'b0;
      end else begin
         blk_cnt <= blk_n;
         blink   <= blink_n;
      end
   end
`endif

   // Outputs are derived from the next state so they land with the state.
   always_comb begin
      val_n   = 10'd0;
      src_n   = cur_n;
      blank_n = 1'b1;
      case (state_n)
         ROTATE: begin
            blank_n = 1'b0;
            case (cur_n)
               2'd1:    val_n = clamp(src1_val);
               2'd2:    val_n = clamp(src2_val);
               default: val_n = clamp(src0_val);
            endcase
         end
         POPUP: begin
            src_n = 2'd3;
            val_n = clamp(pop_lat_n);
`ifdef DISP_ARB_POPUP_BLINK_EN
            blank_n = blink_n;
`else
            blank_n = 1'b0;
`endif
         end
         default: begin
            val_n   = 10'd0;
            blank_n = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cur        <= 2'd0;
         rot_cnt    <= '0;
         hold_cnt   <= '0;
         pop_lat    <= 10'd0;
         pop_ack    <= 1'b0;
         pop_busy   <= 1'b0;
         disp_val   <= 10'd0;
         disp_src   <= 2'd0;
         disp_blank <= 1'b1;
      end else begin
         state      <= state_n;
         cur        <= cur_n;
         rot_cnt    <= rot_n;
         hold_cnt   <= hold_n;
         pop_lat    <= pop_lat_n;
         pop_ack    <= accept;
         pop_busy   <= (state_n == POPUP);
         disp_val   <= val_n;
         disp_src   <= src_n;
         disp_blank <= blank_n;
      end
   end

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: directed table, corner sequences, random vs reference model.
module tb_disp_arbiter;

   localparam int ROT   = 4;
   localparam int HOLD  = 3;
   localparam int BLINK = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [2:0] src_en = 3'b000;
   logic [9:0] v0 = 10'd0;
   logic [9:0] v1 = 10'd0;
   logic [9:0] v2 = 10'd0;
   logic       pop_req = 1'b0;
   logic [9:0] pop_val = 10'd0;
   logic       pop_ack;
   logic       pop_busy;
   logic [9:0] disp_val;
   logic [1:0] disp_src;
   logic       disp_blank;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   bit auto_drop = 1'b1;
   bit rand_tick = 1'b0;

   // reference model: 0 idle, 1 rotating, 2 popup; countdown timers
   int m_mode = 0;
   int m_cur = 0;
   int m_rot_left = ROT;
   int m_hold_left = HOLD;
   int m_blk_left = BLINK;
   int m_pv = 0;
   bit m_ack = 1'b0;
   bit m_ph = 1'b0;
   int e_val, e_src;
   bit e_blank, e_ack, e_busy;

   always #5 clk = ~clk;

   disp_arbiter #(
      .ROT_TICKS(ROT),
      .HOLD_TICKS(HOLD),
      .BLINK_TICKS(BLINK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .src_en(src_en),
      .src0_val(v0),
      .src1_val(v1),
      .src2_val(v2),
      .pop_req(pop_req),
      .pop_val(pop_val),
      .pop_ack(pop_ack),
      .pop_busy(pop_busy),
      .disp_val(disp_val),
      .disp_src(disp_src),
      .disp_blank(disp_blank)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp)
         $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
      else
         n_pass++;
   endtask

   function automatic int first_en(input logic [2:0] en, input int s);
      for (int k = 0; k < 3; k++)
         if (en[(s + k) % 3]) return (s + k) % 3;
      return s % 3;
   endfunction

   function automatic int lim(input int x);
      return (x > 999) ? 999 : x;
   endfunction

   task automatic model_step();
      int vs[3];
      bit acc;
      vs[0] = int'(v0);
      vs[1] = int'(v1);
      vs[2] = int'(v2);
      if (rst) begin
         m_mode = 0;
         m_cur = 0;
         m_ack = 1'b0;
         m_ph = 1'b0;
      end else begin
         acc = pop_req && !m_ack;
         m_ack = acc;
         if (acc) begin
            m_mode = 2;
            m_pv = int'(pop_val);
            m_hold_left = HOLD;
            m_blk_left = BLINK;
            m_ph = 1'b0;
         end else if (m_mode == 0) begin
            if (src_en != 0) begin
               m_mode = 1;
               m_cur = first_en(src_en, m_cur);
               m_rot_left = ROT;
            end
         end else if (m_mode == 1) begin
            if (src_en == 0) begin
               m_mode = 0;
            end else if (!src_en[m_cur]) begin
               m_cur = first_en(src_en, m_cur + 1);
               m_rot_left = ROT;
            end else if (tick) begin
               m_rot_left--;
               if (m_rot_left == 0) begin
                  m_cur = first_en(src_en, m_cur + 1);
                  m_rot_left = ROT;
               end
            end
         end else if (tick) begin
            m_hold_left--;
            m_blk_left--;
            if (m_blk_left == 0) begin
               m_ph = !m_ph;
               m_blk_left = BLINK;
            end
            if (m_hold_left == 0) begin
               if (src_en != 0) begin
                  m_mode = 1;
                  m_rot_left = ROT;
                  m_cur = first_en(src_en, m_cur);
               end else begin
                  m_mode = 0;
               end
            end
         end
      end
      e_ack = m_ack;
      e_busy = (m_mode == 2);
      e_src = (m_mode == 2) ? 3 : m_cur;
      e_val = (m_mode == 0) ? 0 : (m_mode == 1) ? lim(vs[m_cur]) : lim(m_pv);
      e_blank = (m_mode == 0);
`ifdef DISP_ARB_POPUP_BLINK_EN
      if (m_mode == 2) e_blank = m_ph;
`endif
   endtask

   task automatic step(input bit r);
      rst = r;
      if (r) tick = 1'b0;
      else if (rand_tick) tick = ($urandom_range(0, 3) == 0);
      else tick = (cyc % 5 == 4);
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      chk("val", int'(disp_val), e_val);
      chk("src", int'(disp_src), e_src);
      chk("blank", int'(disp_blank), int'(e_blank));
      chk("ack", int'(pop_ack), int'(e_ack));
      chk("busy", int'(pop_busy), int'(e_busy));
      if (auto_drop && pop_ack) pop_req = 1'b0;
   endtask

   typedef struct {
      logic [2:0] en;
      int v0, v1, v2;
      bit req;
      int pval;
      int n;
      int val, src;
      bit blank, ack, busy;
   } vec_t;

   vec_t tbl[18];
   int   ack_exp[4];
   int   exp_b;
   bit   seen;

   initial begin
      tbl[0]  = '{3'b000,   12, 34, 567, 0,   0,  3,   0, 0, 1, 0, 0};
      tbl[1]  = '{3'b101,   12, 34, 567, 0,   0, 10,  12, 0, 0, 0, 0};
      tbl[2]  = '{3'b101,   12, 34, 567, 0,   0, 10, 567, 2, 0, 0, 0};
      tbl[3]  = '{3'b101,   12, 34, 567, 0,   0, 17,  12, 0, 0, 0, 0};
      tbl[4]  = '{3'b001, 1023, 34, 567, 0,   0,  1, 999, 0, 0, 0, 0};
      tbl[5]  = '{3'b001,   42, 34, 567, 0,   0,  1,  42, 0, 0, 0, 0};
      tbl[6]  = '{3'b100,   42, 34, 567, 0,   0,  1, 567, 2, 0, 0, 0};
      tbl[7]  = '{3'b100,   42, 34, 567, 0,   0,  8, 567, 2, 0, 0, 0};
      tbl[8]  = '{3'b100,   42, 34, 567, 1,  88,  1,  88, 3, 0, 1, 1};
      tbl[9]  = '{3'b100,   42, 34, 567, 0,   0, 12,  88, 3, 0, 0, 1};
      tbl[10] = '{3'b101,   42, 34, 567, 0,   0,  1, 567, 2, 0, 0, 0};
      tbl[11] = '{3'b101,   42, 34, 567, 0,   0, 19, 567, 2, 0, 0, 0};
      tbl[12] = '{3'b101,   42, 34, 567, 0,   0,  1,  42, 0, 0, 0, 0};
      tbl[13] = '{3'b101,   42, 34, 567, 1, 300,  1, 300, 3, 0, 1, 1};
      tbl[14] = '{3'b101,   42, 34, 567, 0,   0,  9, 300, 3, 0, 0, 1};
      tbl[15] = '{3'b101,   42, 34, 567, 1,   5,  1,   5, 3, 0, 1, 1};
      tbl[16] = '{3'b000,   42, 34, 567, 0,   0, 13,   5, 3, 0, 0, 1};
      tbl[17] = '{3'b000,   42, 34, 567, 0,   0,  1,   0, 0, 1, 0, 0};

      step(1'b1);
      step(1'b1);
      chk("rst_val", int'(disp_val), 0);
      chk("rst_blank", int'(disp_blank), 1);
      chk("rst_ack", int'(pop_ack), 0);
      chk("rst_busy", int'(pop_busy), 0);
      cyc = 0;

      foreach (tbl[i]) begin
         src_en = tbl[i].en;
         v0 = 10'(tbl[i].v0);
         v1 = 10'(tbl[i].v1);
         v2 = 10'(tbl[i].v2);
         if (tbl[i].req) begin
            pop_req = 1'b1;
            pop_val = 10'(tbl[i].pval);
         end
         for (int k = 0; k < tbl[i].n; k++) step(1'b0);
         chk($sformatf("row%0d_val", i), int'(disp_val), tbl[i].val);
         chk($sformatf("row%0d_src", i), int'(disp_src), tbl[i].src);
         chk($sformatf("row%0d_blank", i), int'(disp_blank),
             int'(tbl[i].blank));
         chk($sformatf("row%0d_ack", i), int'(pop_ack), int'(tbl[i].ack));
         chk($sformatf("row%0d_busy", i), int'(pop_busy), int'(tbl[i].busy));
      end

      // request held through ack: accepted every other clk
      ack_exp = '{1, 0, 1, 0};
      auto_drop = 1'b0;
      pop_req = 1'b1;
      pop_val = 10'd7;
      for (int k = 0; k < 4; k++) begin
         step(1'b0);
         chk($sformatf("rehold_ack%0d", k), int'(pop_ack), ack_exp[k]);
      end
      pop_req = 1'b0;
      auto_drop = 1'b1;

      // fresh popup, first tick afterwards sets blink phase
`ifdef DISP_ARB_POPUP_BLINK_EN
      exp_b = 1;
`else
      exp_b = 0;
`endif
      pop_req = 1'b1;
      pop_val = 10'd1000;
      step(1'b0);
      chk("blink_acc_val", int'(disp_val), 999);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step(1'b0);
         seen = tick;
      end
      chk("blink_tick_seen", int'(seen), 1);
      chk("blink_blank", int'(disp_blank), exp_b);
      chk("blink_busy", int'(pop_busy), 1);

      // reset overrides an active popup
      step(1'b1);
      chk("rst2_busy", int'(pop_busy), 0);
      chk("rst2_blank", int'(disp_blank), 1);
      chk("rst2_src", int'(disp_src), 0);

      rand_tick = 1'b1;
      repeat (1500) begin
         if ($urandom_range(0, 39) == 0) src_en = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) v0 = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 7) == 0) v1 = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 7) == 0) v2 = 10'($urandom_range(0, 1023));
         if (!pop_req && $urandom_range(0, 29) == 0) begin
            pop_req = 1'b1;
            pop_val = 10'($urandom_range(0, 1023));
         end
         step($urandom_range(0, 499) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
